// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronizes and debounces the raw PS/2 lines, then deframes 11-bit scan-code frames.
// Optional macro PS2_RX_ERRCNT_EN enables the saturating bad-frame counter on err_count.
module ps2_rx #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 255,
  parameter int FRAME_TIMEOUT   = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_code,
  output logic       ps2_code_new,
  output logic       valid,
  output logic [7:0] err_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = (FRAME_TIMEOUT < 1) ? 1 : $clog2(FRAME_TIMEOUT + 1);

  if (CLK_FREQ < 1 || FRAME_TIMEOUT < 1) begin : g_bad_cfg
    $error("ps2_rx: CLK_FREQ and FRAME_TIMEOUT must be positive");
  end

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  // Front end: two-flop synchronizers idle high like the PS/2 bus itself.
  logic            clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic            clk_prev_q, clk_prev_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_clk_q, db_clk_d;
  logic            db_dly_q, db_dly_d;
  logic            fall;

  always_comb begin
    clk_prev_d = clk_s2_q;
    db_dly_d   = db_clk_q;
    db_clk_d   = db_clk_q;
    db_cnt_d   = db_cnt_q;
    if (clk_s2_q != clk_prev_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q != DB_W'(DEBOUNCE_CYCLES)) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    if (clk_s2_q == clk_prev_q && db_cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
      db_clk_d = clk_s2_q;
    end
  end

  assign fall = db_dly_q & ~db_clk_q;

  // NOTE: every flop here uses non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
      clk_prev_q <= 1'b1;
      db_cnt_q   <= '0;
      db_clk_q   <= 1'b1;
      db_dly_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      data_s1_q  <= ps2_data;
      data_s2_q  <= data_s1_q;
      clk_prev_q <= clk_prev_d;
      db_cnt_q   <= db_cnt_d;
      db_clk_q   <= db_clk_d;
      db_dly_q   <= db_dly_d;
    end
  end

  state_t          state_q;
  logic [3:0]      bit_cnt_q;
  logic [10:0]     shift_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [7:0]      code_q;
  logic            code_new_q;
  logic            valid_q;
  logic            frame_good;
  logic            timed_out;

  // Bits arrive LSB first, so after 11 shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign frame_good = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);
  assign timed_out  = (to_cnt_q == TO_W'(FRAME_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      to_cnt_q   <= '0;
      code_q     <= 8'h00;
      code_new_q <= 1'b1;
      valid_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          if (fall) begin
            shift_q    <= {data_s2_q, shift_q[10:1]};
            bit_cnt_q  <= 4'd1;
            code_new_q <= 1'b0;
            state_q    <= RECV;
          end
        end
        RECV: begin
          if (fall) begin
            shift_q   <= {data_s2_q, shift_q[10:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            to_cnt_q  <= '0;
            if (bit_cnt_q == 4'd10) state_q <= CHECK;
          end else if (timed_out) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            valid_q   <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        CHECK: begin
          state_q   <= IDLE;
          bit_cnt_q <= '0;
          if (frame_good) begin
            code_q     <= shift_q[8:1];
            valid_q    <= 1'b1;
            code_new_q <= 1'b1;
          end else begin
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ps2_code     = code_q;
  assign ps2_code_new = code_new_q;
  assign valid        = valid_q;

`ifdef PS2_RX_ERRCNT_EN
  logic [7:0] err_q;
  logic       err_inc;

  assign err_inc = (state_q == CHECK && !frame_good) ||
                   (state_q == RECV && !fall && timed_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 8'h00;
    end else if (err_inc && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_rx.sv
// Directed self-checking bench for ps2_rx; short debounce/timeout parameters keep the run brief.
module tb_ps2_rx;

  localparam int DB   = 4;
  localparam int TO   = 200;
  localparam int HALF = 12;
`ifdef PS2_RX_ERRCNT_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ps2_code;
  logic       ps2_code_new;
  logic       valid;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  ps2_rx #(
    .CLK_FREQ       (50_000_000),
    .DEBOUNCE_CYCLES(DB),
    .FRAME_TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_code    (ps2_code),
    .ps2_code_new(ps2_code_new),
    .valid       (valid),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (observed running, expected finished)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic stop, input logic par,
                                        input logic [7:0] data, input logic start);
    return {stop, par, data, start};
  endfunction

  // Drives n bits of a frame; data changes while ps2_clk is high. With chk set, the
  // 11th fall strobe is located and ps2_code_new is checked one and two cycles later.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit chk, input logic exp_new);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (chk && i == 5) begin
        @(negedge clk);
        check("new_low_mid_frame", 32'(ps2_code_new), 32'd0);
      end
      if (chk && i == n - 1) begin
        int waited = 0;
        while (dut.fall !== 1'b1 && waited < 50) begin
          @(negedge clk);
          waited++;
        end
        check("last_strobe_seen", 32'(dut.fall), 32'd1);
        @(negedge clk);
        check("new_in_check", 32'(ps2_code_new), 32'd0);
        @(negedge clk);
        check("new_after_check", 32'(ps2_code_new), 32'(exp_new));
      end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] code, input logic nw,
                            input logic vld, input int errs);
    check({tag, "_code"}, 32'(ps2_code), 32'(code));
    check({tag, "_new"}, 32'(ps2_code_new), 32'(nw));
    check({tag, "_valid"}, 32'(valid), 32'(vld));
    check({tag, "_err"}, 32'(err_count), 32'(errs * ERR_ON));
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check_outs("reset", 8'h00, 1'b1, 1'b1, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_outs("post_reset_idle", 8'h00, 1'b1, 1'b1, 0);

    // Good 0x1C: three ones, so odd parity bit is 0.
    send_bits(frame(1'b1, 1'b0, 8'h1C, 1'b0), 11, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check_outs("good_1c", 8'h1C, 1'b1, 1'b1, 0);

    // Glitch shorter than the debounce window while idle.
    ps2_clk = 1'b0;
    repeat (DB - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clk);
    check_outs("glitch", 8'h1C, 1'b1, 1'b1, 0);

    // 0x1C with wrong parity bit 1.
    send_bits(frame(1'b1, 1'b1, 8'h1C, 1'b0), 11, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check_outs("bad_parity", 8'h1C, 1'b0, 1'b0, 1);

    // Start bit of 1 with otherwise valid content runs to CHECK and is rejected.
    send_bits(frame(1'b1, 1'b0, 8'h55, 1'b1), 11, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check_outs("bad_start", 8'h1C, 1'b0, 1'b0, 2);

    // Five bits of a frame, then the bus stalls past the timeout.
    send_bits(frame(1'b1, 1'b0, 8'hA5, 1'b0), 5, 1'b0, 1'b0);
    repeat (TO / 2) @(negedge clk);
    check("mid_stall_valid", 32'(valid), 32'd0);
    check("mid_stall_err", 32'(err_count), 32'(2 * ERR_ON));
    repeat (TO + 20) @(negedge clk);
    check_outs("timeout", 8'h1C, 1'b0, 1'b0, 3);

    // Good 0xF0: four ones, parity bit 1.
    send_bits(frame(1'b1, 1'b1, 8'hF0, 1'b0), 11, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check_outs("good_f0", 8'hF0, 1'b1, 1'b1, 3);

    // Reset after six bits discards the partial frame.
    send_bits(frame(1'b1, 1'b1, 8'h3C, 1'b0), 6, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_outs("mid_frame_reset", 8'h00, 1'b1, 1'b1, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Good 0xE0: three ones, parity bit 0.
    send_bits(frame(1'b1, 1'b0, 8'hE0, 1'b0), 11, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check_outs("good_e0", 8'hE0, 1'b1, 1'b1, 0);

`ifdef PS2_RX_ERRCNT_EN
    for (int f = 0; f < 255; f++) begin
      send_bits(frame(1'b0, 1'b0, 8'hE0, 1'b0), 11, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
    end
    check("err_at_255", 32'(err_count), 32'hFF);
    send_bits(frame(1'b0, 1'b0, 8'hE0, 1'b0), 11, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("err_saturated", 32'(err_count), 32'hFF);
    check("sat_code_kept", 32'(ps2_code), 32'hE0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz (informational; other parameters are expressed in cycles).
REQ-002 Parameter DEBOUNCE_CYCLES, default 255: number of consecutive stable cycles required before the debounced ps2_clk accepts a new level.
REQ-003 Parameter FRAME_TIMEOUT, default 100_000: maximum number of cycles allowed between falling edges inside a frame (2 ms at 50 MHz).
REQ-004 clk  in  1  system clock; all logic is rising-edge clocked.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 ps2_clk  in  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-007 ps2_data  in  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-008 ps2_code  out  8  last correctly received scan code.
REQ-009 ps2_code_new  out  1  high while idle after a good frame; low from the start of a frame until the next good frame completes.
REQ-010 valid  out  1  result of the last completed or aborted frame: 1 = good, 0 = error.
REQ-011 err_count  out  8  saturating count of bad or aborted frames (see Configuration).

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce: a counter SHALL clear whenever synced ps2_clk differs from its value on the previous cycle; when the counter reaches DEBOUNCE_CYCLES, the debounced clock SHALL take the synced value.
REQ-014 The fall strobe SHALL be a 1-cycle pulse on the cycle the debounced clock changes from 1 to 0; synced ps2_data SHALL be sampled in that cycle.
REQ-015 Frame format SHALL be 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1).
REQ-016 FSM states SHALL be IDLE, RECV and CHECK.
REQ-017 IDLE→RECV on a fall strobe; the start bit SHALL be captured, the bit count set to 1, and ps2_code_new driven to 0.
REQ-018 In RECV, each fall strobe SHALL shift in one bit and clear the timeout counter; after the 11th bit, the FSM SHALL enter CHECK on the next cycle.
REQ-019 CHECK SHALL last exactly one cycle, then return to IDLE.
REQ-020 A frame is good when start=0, stop=1 and the XOR of the 8 data bits plus the parity bit equals 1.
REQ-021 On the clock edge ending CHECK for a good frame: ps2_code ← data, valid ← 1, ps2_code_new ← 1 (rising edge).
REQ-022 For a bad frame: ps2_code SHALL be unchanged, valid ← 0, ps2_code_new SHALL remain 0, and err_count SHALL increment.
REQ-023 In RECV, if the timeout counter reaches FRAME_TIMEOUT, the frame SHALL be aborted: IDLE, bit count cleared, valid ← 0, err_count increments, ps2_code_new remains 0.
REQ-024 A start bit of 1 SHALL be accepted into RECV and then rejected at CHECK as a bad frame (no early abort).
REQ-025 A fall strobe during CHECK cannot occur within DEBOUNCE_CYCLES ≥ 2; for DEBOUNCE_CYCLES < 2 it SHALL be ignored.
REQ-026 Glitches on ps2_clk shorter than DEBOUNCE_CYCLES cycles SHALL produce no strobe.

Reset
REQ-027 While rst=1: FSM in IDLE, bit count 0, shift register 0, ps2_code = 8'h00, ps2_code_new = 1, valid = 1, err_count = 0, debounced clock = 1, synchronizer flops = 1, all counters 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first fall strobe after release SHALL start a new frame.

Configuration
REQ-029 Macro PS2_RX_ERRCNT_EN: when defined, err_count SHALL be an 8-bit counter that saturates at 8'hFF, incremented by REQ-022 and REQ-023; when undefined, err_count SHALL be tied to 8'h00 and the counter logic SHALL be absent. The port list is identical in both builds.

Verification
REQ-030 Good frame 0x1C (parity bit 0) at a 12 kHz PS/2 clock → ps2_code=8'h1C, valid=1, ps2_code_new low during the frame and rising 2 cycles after the 11th fall strobe.
REQ-031 Frame 0x1C with parity bit 1 → ps2_code keeps its previous value, valid=0, ps2_code_new stays 0, err_count=1 (macro defined) or 0 (macro undefined).
REQ-032 50-cycle low glitch on ps2_clk while idle, DEBOUNCE_CYCLES=255 → no state change; ps2_code_new stays 1.
REQ-033 5 bits sent, then ps2_clk held high for 100_000 cycles → abort, valid=0, err_count+1; a following good frame 0xF0 → ps2_code=8'hF0, valid=1.
REQ-034 rst pulsed after 6 bits of a frame → all outputs at reset values; a following good frame 0xE0 → ps2_code=8'hE0, ps2_code_new rises.
REQ-035 256 consecutive bad frames with macro defined → err_count saturates at 8'hFF.
